// File: rtl/seg7_letter_decoder.sv
// Active-low 7-segment pattern to letter code decoder with output FIFO.
// Optional saturating error counter: define SEG7_DECODER_ERR_COUNT_EN.
module seg7_letter_decoder #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             Reset_n,
    input  logic [6:0]       Seg_In,
    input  logic             Seg_Valid,
    output logic             Seg_Ready,
    output logic [4:0]       Code_Out,
    output logic             Err_Out,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [ERR_W-1:0] Err_Count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [4:0]    dec_code;
    logic          dec_err;
    logic          push;
    logic          pop;

    logic [5:0]    mem_q [DEPTH];
    logic [5:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pattern lookup; anything outside the glyph table maps to code 31
    always_comb begin
        dec_code = 5'd31;
        dec_err  = 1'b0;
        unique case (Seg_In)
            7'b1111111: dec_code = 5'd0;
            7'b0001000: dec_code = 5'd1;
            7'b0000011: dec_code = 5'd2;
            7'b1000110: dec_code = 5'd3;
            7'b0100001: dec_code = 5'd4;
            7'b0000110: dec_code = 5'd5;
            7'b0001110: dec_code = 5'd6;
            7'b0010000: dec_code = 5'd7;
            7'b0001011: dec_code = 5'd8;
            7'b1111001: dec_code = 5'd9;
            7'b1110001: dec_code = 5'd10;
            7'b0001001: dec_code = 5'd11;
            7'b1000111: dec_code = 5'd12;
            7'b1001000: dec_code = 5'd13;
            7'b0101011: dec_code = 5'd14;
            7'b0101010: dec_code = 5'd15;
            7'b1000000: dec_code = 5'd16;
            7'b0001100: dec_code = 5'd17;
            7'b0011000: dec_code = 5'd18;
            7'b0101111: dec_code = 5'd19;
            7'b0010010: dec_code = 5'd20;
            7'b0000111: dec_code = 5'd21;
            7'b1100011: dec_code = 5'd22;
            7'b1000001: dec_code = 5'd23;
            7'b0110000: dec_code = 5'd24;
            7'b0000101: dec_code = 5'd25;
            7'b0010001: dec_code = 5'd26;
            7'b0100100: dec_code = 5'd27;
            default: begin
                dec_code = 5'd31;
                dec_err  = 1'b1;
            end
        endcase
    end

    // Handshake flags come only from registered occupancy
    always_comb begin
        Seg_Ready = (count_q != FULL_CNT);
        Out_Valid = (count_q != '0);
        push      = Seg_Valid & Seg_Ready;
        pop       = Out_Valid & Out_Ready;
        Code_Out  = mem_q[rd_ptr_q][4:0];
        Err_Out   = mem_q[rd_ptr_q][5];
    end

    // Next FIFO storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {dec_err, dec_code};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset clears storage so Code_Out reads 0
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef SEG7_DECODER_ERR_COUNT_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    // Count accepted unrecognised patterns, holding at all-ones
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (push && dec_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // Error counter register
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign Err_Count = err_cnt_q;
`else
    assign Err_Count = '0;
`endif

endmodule

// File: tb/tb_seg7_letter_decoder.sv
// Directed bench for seg7_letter_decoder with immediate assertions.
// Err_Count expectations follow SEG7_DECODER_ERR_COUNT_EN.
module tb_seg7_letter_decoder;

    logic       clock = 1'b0;
    logic       Reset_n = 1'b1;
    logic [6:0] Seg_In = 7'b1111111;
    logic       Seg_Valid = 1'b0;
    logic       Seg_Ready;
    logic [4:0] Code_Out;
    logic       Err_Out;
    logic       Out_Valid;
    logic       Out_Ready = 1'b0;
    logic [7:0] Err_Count;

    int checks = 0;
    int errors = 0;

    logic [6:0] pats [28];

`ifdef SEG7_DECODER_ERR_COUNT_EN
    localparam logic [7:0] EXP_E1 = 8'd1;
    localparam logic [7:0] EXP_E2 = 8'd2;
`else
    localparam logic [7:0] EXP_E1 = 8'd0;
    localparam logic [7:0] EXP_E2 = 8'd0;
`endif

    seg7_letter_decoder #(.DEPTH(4), .ERR_W(8)) dut (
        .clock     (clock),
        .Reset_n   (Reset_n),
        .Seg_In    (Seg_In),
        .Seg_Valid (Seg_Valid),
        .Seg_Ready (Seg_Ready),
        .Code_Out  (Code_Out),
        .Err_Out   (Err_Out),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Err_Count (Err_Count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int q [$];
        int cnt;
        int nxt;
        bit acc;
        bit pp;

        pats[0]  = 7'b1111111; pats[1]  = 7'b0001000;
        pats[2]  = 7'b0000011; pats[3]  = 7'b1000110;
        pats[4]  = 7'b0100001; pats[5]  = 7'b0000110;
        pats[6]  = 7'b0001110; pats[7]  = 7'b0010000;
        pats[8]  = 7'b0001011; pats[9]  = 7'b1111001;
        pats[10] = 7'b1110001; pats[11] = 7'b0001001;
        pats[12] = 7'b1000111; pats[13] = 7'b1001000;
        pats[14] = 7'b0101011; pats[15] = 7'b0101010;
        pats[16] = 7'b1000000; pats[17] = 7'b0001100;
        pats[18] = 7'b0011000; pats[19] = 7'b0101111;
        pats[20] = 7'b0010010; pats[21] = 7'b0000111;
        pats[22] = 7'b1100011; pats[23] = 7'b1000001;
        pats[24] = 7'b0110000; pats[25] = 7'b0000101;
        pats[26] = 7'b0010001; pats[27] = 7'b0100100;

        // reset state
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_seg_ready", 32'(Seg_Ready), 32'd1);
        chk("rst_out_valid", 32'(Out_Valid), 32'd0);
        chk("rst_code", 32'(Code_Out), 32'd0);
        chk("rst_err", 32'(Err_Out), 32'd0);
        chk("rst_err_cnt", 32'(Err_Count), 32'd0);
        tick();
        tick();
        Reset_n = 1'b1;
        tick();

        // three back-to-back accepts with consumer ready
        Out_Ready = 1'b1;
        Seg_Valid = 1'b1;
        Seg_In = 7'b0001000;
        tick();
        chk("b2b_valid1", 32'(Out_Valid), 32'd1);
        chk("b2b_code1", 32'(Code_Out), 32'd1);
        chk("b2b_err1", 32'(Err_Out), 32'd0);
        Seg_In = 7'b0000011;
        tick();
        chk("b2b_code2", 32'(Code_Out), 32'd2);
        Seg_In = 7'b1000110;
        tick();
        chk("b2b_code3", 32'(Code_Out), 32'd3);
        chk("b2b_err3", 32'(Err_Out), 32'd0);
        Seg_Valid = 1'b0;
        tick();
        chk("b2b_empty", 32'(Out_Valid), 32'd0);

        // sweep the full glyph table
        Seg_Valid = 1'b1;
        for (int i = 0; i < 28; i++) begin
            Seg_In = pats[i];
            tick();
            chk($sformatf("sweep_valid%0d", i), 32'(Out_Valid), 32'd1);
            chk($sformatf("sweep_code%0d", i), 32'(Code_Out), 32'(i));
            chk($sformatf("sweep_err%0d", i), 32'(Err_Out), 32'd0);
        end
        Seg_Valid = 1'b0;
        tick();
        chk("sweep_empty", 32'(Out_Valid), 32'd0);

        // unrecognised pattern
        Seg_Valid = 1'b1;
        Seg_In = 7'b1010101;
        tick();
        chk("bad_code", 32'(Code_Out), 32'd31);
        chk("bad_err", 32'(Err_Out), 32'd1);
        chk("bad_err_cnt", 32'(Err_Count), 32'(EXP_E1));
        Seg_Valid = 1'b0;
        tick();
        chk("bad_empty", 32'(Out_Valid), 32'd0);
        chk("bad_err_cnt_hold", 32'(Err_Count), 32'(EXP_E1));

        // fill to full, hold fifth, pop once
        Out_Ready = 1'b0;
        Seg_Valid = 1'b1;
        for (int i = 5; i < 9; i++) begin
            Seg_In = pats[i];
            tick();
            chk($sformatf("fill_ready%0d", i), 32'(Seg_Ready),
                (i < 8) ? 32'd1 : 32'd0);
        end
        chk("full_head", 32'(Code_Out), 32'd5);
        Seg_In = pats[9];
        tick();
        chk("full_drop_ready", 32'(Seg_Ready), 32'd0);
        chk("full_drop_head", 32'(Code_Out), 32'd5);
        Out_Ready = 1'b1;
        tick();
        chk("pop_full_ready", 32'(Seg_Ready), 32'd1);
        chk("pop_full_head", 32'(Code_Out), 32'd6);
        Out_Ready = 1'b0;
        tick();
        chk("refill_ready", 32'(Seg_Ready), 32'd0);
        chk("refill_head", 32'(Code_Out), 32'd6);
        Seg_Valid = 1'b0;
        Out_Ready = 1'b1;
        for (int i = 7; i < 10; i++) begin
            tick();
            chk($sformatf("drain_code%0d", i), 32'(Code_Out), 32'(i));
        end
        tick();
        chk("drain_empty", 32'(Out_Valid), 32'd0);

        // full FIFO with source and consumer both active
        Out_Ready = 1'b0;
        Seg_Valid = 1'b1;
        for (int i = 10; i < 14; i++) begin
            Seg_In = pats[i];
            tick();
            q.push_back(i);
        end
        chk("stream_full", 32'(Seg_Ready), 32'd0);
        cnt = 4;
        nxt = 14;
        Out_Ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            Seg_In = pats[nxt];
            acc = (cnt < 4);
            pp = (cnt > 0);
            tick();
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(nxt);
                nxt++;
            end
            cnt = q.size();
            chk($sformatf("stream_valid%0d", c), 32'(Out_Valid),
                32'(cnt > 0));
            chk($sformatf("stream_ready%0d", c), 32'(Seg_Ready),
                32'(cnt < 4));
            chk($sformatf("stream_code%0d", c), 32'(Code_Out), 32'(q[0]));
        end
        Seg_Valid = 1'b0;
        while (q.size() > 0) begin
            tick();
            void'(q.pop_front());
            if (q.size() > 0)
                chk("stream_drain", 32'(Code_Out), 32'(q[0]));
        end
        chk("stream_empty", 32'(Out_Valid), 32'd0);

        // asynchronous reset with entries queued
        Out_Ready = 1'b0;
        Seg_Valid = 1'b1;
        Seg_In = pats[1];
        tick();
        Seg_In = 7'b1010101;
        tick();
        Seg_In = pats[2];
        tick();
        Seg_Valid = 1'b0;
        chk("mid_valid", 32'(Out_Valid), 32'd1);
        chk("mid_head", 32'(Code_Out), 32'd1);
        chk("mid_err_cnt", 32'(Err_Count), 32'(EXP_E2));
        #2 Reset_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(Out_Valid), 32'd0);
        chk("async_seg_ready", 32'(Seg_Ready), 32'd1);
        chk("async_err_cnt", 32'(Err_Count), 32'd0);
        chk("async_code", 32'(Code_Out), 32'd0);
        chk("async_err", 32'(Err_Out), 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(Out_Valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
